// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the SLC-3 memory responder
// Purpose: responder state encoding, word width and the memory-mapped I/O address.
// Ports: none (package).
package mem_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] IO_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - on-chip word array behind the memory responder
// Purpose: 2**DEPTH_LOG2 words, combinational read, synchronous write, no reset.
// Ports:
//   clk_i    in  clock for the write port
//   we_i     in  write enable
//   index_i  in  word index, shared by the read and write ports
//   data_i   in  write data
//   rdata_o  out combinational read data at index_i
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] index_i,
  input  logic [WORD_W-1:0]     data_i,
  output logic [WORD_W-1:0]     rdata_o
);

  logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[index_i] <= data_i;
    end
  end

  assign rdata_o = mem_q[index_i];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - MAR/MDR request responder with programmable wait states
// Purpose: services CPU read/write requests after WAIT_STATES cycles and pulses
//   mem_r on completion. Optional switch/hex I/O at 0xFFFF when MEM_IO_MAP_EN is defined.
// Ports:
//   Clk, Reset         clock, synchronous active-high reset
//   mem_en, mem_we     request valid, 1 = write (sampled in IDLE only)
//   addr, wdata        word address and write data (latched with mem_en)
//   rdata              registered read data, held until the next read completes
//   mem_r              one-cycle completion pulse
//   busy               high whenever the responder is not IDLE
//   switches, hex_out  I/O-map switch input and hex-display register
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned DEPTH_LOG2  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              mem_r,
  output logic              busy,
  input  logic [WORD_W-1:0] switches,
  output logic [WORD_W-1:0] hex_out
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic                    io_q, io_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]       wdata_q, wdata_d;
  logic [WORD_W-1:0]       rdata_q, rdata_d;

  logic                    enter_resp;
  logic                    addr_is_io;
  logic [WORD_W-1:0]       io_rdata;
  logic                    arr_we;
  logic [WORD_W-1:0]       arr_rdata;

`ifdef MEM_IO_MAP_EN
  logic [WORD_W-1:0] hex_q, hex_d;

  assign addr_is_io = (addr == IO_ADDR);
  assign io_rdata   = switches;

  always_comb begin
    hex_d = hex_q;
    if (enter_resp && we_d && io_d) begin
      hex_d = wdata_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hex_q <= '0;
    end else begin
      hex_q <= hex_d;
    end
  end

  assign hex_out = hex_q;
`else
  logic unused_io;

  assign addr_is_io = 1'b0;
  assign io_rdata   = '0;
  assign hex_out    = '0;
  // Switches and the upper address bits have no function without the I/O map.
  assign unused_io  = ^{switches, addr[WORD_W-1:DEPTH_LOG2]};
`endif

  // The *_d latch values always describe the transaction being serviced: in IDLE
  // they are the live inputs, afterwards the held copies. Using them for the array
  // and rdata lets WAIT_STATES=0 enter RESP on the very edge that samples mem_en.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    io_d       = io_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_en) begin
          we_d    = mem_we;
          io_d    = addr_is_io;
          idx_d   = addr[DEPTH_LOG2-1:0];
          wdata_d = wdata;
          cnt_d   = WAIT_INIT;
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp && !we_d) begin
      rdata_d = io_d ? io_rdata : arr_rdata;
    end
  end

  // Gating with Reset drops a write whose RESP entry coincides with reset.
  assign arr_we = enter_resp && we_d && !io_d && !Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      io_q    <= io_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i   (Clk),
    .we_i    (arr_we),
    .index_i (idx_d),
    .data_i  (wdata_d),
    .rdata_o (arr_rdata)
  );

  assign rdata = rdata_q;
  assign mem_r = (state_q == RESP);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (honours MEM_IO_MAP_EN)
module tb_mem_responder;

  localparam int WS = 2;
  localparam int DL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_we;
  logic [15:0] addr, wdata, switches;
  logic [15:0] rdata, hex_out;
  logic        mem_r, busy;

  logic        en0, we0;
  logic [15:0] a0, d0, sw0;
  logic [15:0] rdata0, hex0;
  logic        r0, busy0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_STATES(WS), .DEPTH_LOG2(DL)) u_dut (
    .Clk(clk), .Reset(rst), .mem_en(mem_en), .mem_we(mem_we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .mem_r(mem_r), .busy(busy),
    .switches(switches), .hex_out(hex_out)
  );

  mem_responder #(.WAIT_STATES(0), .DEPTH_LOG2(DL)) u_dut0 (
    .Clk(clk), .Reset(rst), .mem_en(en0), .mem_we(we0), .addr(a0),
    .wdata(d0), .rdata(rdata0), .mem_r(r0), .busy(busy0),
    .switches(sw0), .hex_out(hex0)
  );

  typedef struct {
    int          issue;
    int          resp;
    bit          rd;
    logic [15:0] data;
    logic [15:0] hex;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] model [256];
  logic [15:0] hex_model;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          skip_busy = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_io(input logic [15:0] a);
`ifdef MEM_IO_MAP_EN
    return a == 16'hFFFF;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: busy must be high from the cycle after issue through the pulse;
  // every mem_r pulse must match the oldest outstanding transaction.
  always @(negedge clk) begin
    exp_t e;
    bit   bexp;
    if (!rst && !skip_busy) begin
      bexp = (sbq.size() > 0) && (cyc > sbq[0].issue) && (cyc <= sbq[0].resp);
      chk("busy", {31'd0, busy}, {31'd0, bexp});
    end
    if (mem_r) begin
      if (sbq.size() == 0) begin
        chk("mem_r_unexpected", {31'd0, mem_r}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("mem_r_cycle", cyc, e.resp);
        if (e.rd) chk("rdata", {16'd0, rdata}, {16'd0, e.data});
        chk("hex_out", {16'd0, hex_out}, {16'd0, e.hex});
      end
    end else if (sbq.size() > 0 && cyc >= sbq[0].resp) begin
      chk("mem_r_missing", {31'd0, mem_r}, 32'd1);
      void'(sbq.pop_front());
    end
  end

  // Issue one transaction in an IDLE cycle (called at a falling edge), keep the
  // inputs busy with junk while the responder works, then leave `gap` idle cycles.
  task automatic do_txn(input bit we, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] sw, input int gap, input bit garble);
    exp_t e;
    mem_en   = 1'b1;
    mem_we   = we;
    addr     = a;
    wdata    = d;
    switches = sw;
    e.issue  = cyc;
    e.resp   = cyc + WS + 1;
    e.rd     = !we;
    e.data   = 16'h0000;
    if (we) begin
      if (is_io(a)) hex_model = d;
      else model[a[7:0]] = d;
    end else begin
      e.data = is_io(a) ? sw : model[a[7:0]];
    end
    e.hex = hex_model;
    sbq.push_back(e);
    @(negedge clk);
    for (int i = 0; i < WS + 1; i++) begin
      if (garble) begin
        mem_en = 1'($urandom);
        mem_we = 1'($urandom);
        addr   = 16'($urandom);
        wdata  = 16'($urandom);
      end else begin
        mem_en = 1'b0;
      end
      @(negedge clk);
    end
    mem_en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    logic [15:0] ra;
    int          waited;
    rst = 1'b1;
    mem_en = 1'b0; mem_we = 1'b0; addr = '0; wdata = '0; switches = '0;
    en0 = 1'b0; we0 = 1'b0; a0 = '0; d0 = '0; sw0 = '0;
    hex_model = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_mem_r", {31'd0, mem_r}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hex", {16'd0, hex_out}, 32'd0);
    chk("rst0_rdata", {16'd0, rdata0}, 32'd0);
    chk("rst0_busy", {31'd0, busy0}, 32'd0);
    rst = 1'b0;

    // Fill the whole array so every later read has a known expectation.
    for (int i = 0; i < 256; i++) do_txn(1'b1, 16'(i), 16'($urandom), 16'h0, 0, 1'b1);

    do_txn(1'b1, 16'h0010, 16'h1234, 16'h0, 1, 1'b0);
    do_txn(1'b0, 16'h0010, 16'h0000, 16'h0, 1, 1'b0);
    do_txn(1'b1, 16'h0105, 16'hBEEF, 16'h0, 0, 1'b1);
    do_txn(1'b0, 16'h0005, 16'h0000, 16'h0, 2, 1'b1);
    do_txn(1'b0, 16'hFFFF, 16'h0000, 16'h00C3, 0, 1'b0);
    do_txn(1'b1, 16'hFFFF, 16'h0042, 16'h0, 0, 1'b0);
    do_txn(1'b0, 16'h00FF, 16'h0000, 16'h0, 1, 1'b0);
    // Back-to-back reads with mem_en held high.
    do_txn(1'b0, 16'h0010, 16'h0000, 16'h0, 0, 1'b0);
    mem_en = 1'b1;
    do_txn(1'b0, 16'h0005, 16'h0000, 16'h0, 1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      ra = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
      do_txn(1'($urandom), ra, 16'($urandom), 16'($urandom), $urandom_range(2), 1'($urandom));
    end

    // Reset while a write sits in WAIT: it must vanish without a pulse.
    do_txn(1'b1, 16'h0020, 16'h5555, 16'h0, 0, 1'b0);
    skip_busy = 1'b1;
    mem_en = 1'b1; mem_we = 1'b1; addr = 16'h0020; wdata = 16'hAAAA;
    @(negedge clk);
    mem_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_r", {31'd0, mem_r}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rdata", {16'd0, rdata}, 32'd0);
    chk("midrst_hex", {16'd0, hex_out}, 32'd0);
    rst = 1'b0;
    hex_model = 16'h0000;
    @(negedge clk);
    skip_busy = 1'b0;
    do_txn(1'b0, 16'h0020, 16'h0000, 16'h0, 1, 1'b0);

    waited = 0;
    while (sbq.size() > 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("drain", sbq.size(), 32'd0);

    // Zero-wait-state instance: pulse in cycle 1, period 2 with mem_en held.
    en0 = 1'b1; we0 = 1'b1; a0 = 16'h0033; d0 = 16'h7777;
    @(negedge clk);
    chk("ws0_wr_mem_r", {31'd0, r0}, 32'd1);
    chk("ws0_wr_busy", {31'd0, busy0}, 32'd1);
    we0 = 1'b0; d0 = 16'h0000;
    @(negedge clk);
    chk("ws0_gap_mem_r", {31'd0, r0}, 32'd0);
    chk("ws0_gap_busy", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    chk("ws0_rd_mem_r", {31'd0, r0}, 32'd1);
    chk("ws0_rd_rdata", {16'd0, rdata0}, 32'h7777);
    en0 = 1'b0;
    @(negedge clk);
    chk("ws0_idle_mem_r", {31'd0, r0}, 32'd0);
    chk("ws0_rdata_held", {16'd0, rdata0}, 32'h7777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
